muldiv_seq_unit: RTL and testbench
==================================

Name: muldiv_seq_unit

Overview:
- Multi-cycle RV32M multiply/divide responder in the EX stage, sitting beside the single-cycle ALU.
- The ALU/EX control issues a request: operands, M-extension func3 and a START pulse.
- The unit iterates one bit per cycle and returns a 32-bit result with a one-cycle DONE pulse.
- BUSY stalls the pipeline while an operation is in flight.

Parameters:
- XLEN, 32, operand/result width. Only 32 is required; the cycle count below assumes XLEN.

Ports:
- CLK  input  1  rising-edge clock.
- RESET  input  1  asynchronous, active-low reset.
- START  input  1  request strobe. Sampled on the rising edge; accepted only when BUSY=0.
- DATA1  input  32  rs1 operand: multiplicand or dividend.
- DATA2  input  32  rs2 operand: multiplier or divisor.
- SELECT  input  3  func3 encoding:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- BUSY  output  1  high while an accepted operation is in progress.
- DONE  output  1  one-cycle pulse; RESULT is valid in that cycle.
- RESULT  output  32  result register. Holds its value until the next DONE.

Behaviour:
- Reset (RESET=0, asynchronous):
  - State goes to IDLE.
  - BUSY=0, DONE=0, RESULT=0.
  - The internal counter and accumulators are cleared.
  - Reset asserted mid-operation aborts the operation; no DONE is issued.
- States: IDLE -> CALC -> FIX -> IDLE.
- IDLE:
  - When START=1 at a clock edge, capture DATA1, DATA2 and SELECT.
  - Set BUSY=1, counter=0, go to CALC.
  - Operand changes after the accepting edge have no effect.
- Operand preparation at accept:
  - Signed operands: DATA1 for MULH/MULHSU/DIV/REM; DATA2 for MULH/DIV/REM.
  - Signed operands are converted to magnitudes, and their sign bits are recorded.
  - Unsigned operands are used as-is.
- CALC runs exactly 32 cycles; the counter counts 0..31.
  - Multiply: radix-2 shift-add into a 64-bit unsigned product of the magnitudes.
  - Divide: restoring division producing 32-bit quotient and remainder magnitudes.
  - At counter=31, go to FIX.
- FIX takes one cycle. It registers RESULT, pulses DONE=1, clears BUSY and returns to IDLE.
  - The DONE/RESULT cycle therefore starts 33 edges after the accepting edge.
- Sign fix for multiply:
  - Negate the 64-bit product (two's complement) if the operand signs differ.
  - MUL returns the low 32 bits.
  - MULH, MULHSU and MULHU return the high 32 bits.
- Sign fix for divide:
  - The quotient is negated if the signs differ (DIV only).
  - The remainder takes the dividend's sign (REM only).
- Divide by zero (DATA2=0), overriding the sign fix:
  - DIV/DIVU return 0xFFFFFFFF.
  - REM/REMU return DATA1 unchanged.
  - Full latency still applies.
- Signed overflow (DIV/REM with DATA1=0x80000000, DATA2=0xFFFFFFFF):
  - DIV returns 0x80000000; REM returns 0.
  - Full latency still applies.
- Handshake rules:
  - START while BUSY=1 is ignored; it is neither queued nor allowed to corrupt the captured operands.
  - START in the DONE cycle is accepted, giving back-to-back operation.
  - BUSY rises again at that edge, and the next DONE follows 33 edges later.
- DONE is never high for two consecutive cycles.
- No arithmetic exceptions or traps are raised.

Test Plan:
- Reset release, START=1, SELECT=000, DATA1=7, DATA2=6.
  - BUSY=1 for 33 cycles.
  - DONE pulses once with RESULT=0x0000002A.
  - Then BUSY=0 and DONE=0.
- MULH with 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000000.
  - MULHU with the same operands -> 0xFFFFFFFE.
  - MULHSU with the same operands -> 0xFFFFFFFF.
  - MUL with the same operands -> 0x00000001.
- DIV -7/2 -> 0xFFFFFFFD (-3).
  - REM -7/2 -> 0xFFFFFFFF (-1).
  - DIVU 0xFFFFFFF9/2 -> 0x7FFFFFFC.
  - REMU 0xFFFFFFF9/2 -> 1.
- Corner cases:
  - DIV 5/0 -> 0xFFFFFFFF.
  - REM 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - REM with the same operands -> 0.
- Hold-off and back-to-back:
  - START pulses with new operands at cycles 5 and 20 after accept are ignored.
  - The result matches the originally captured operands.
  - START in the DONE cycle starts a second operation, whose DONE is 33 edges later.
- Mid-operation reset:
  - RESET=0 asynchronously at cycle 10 of CALC.
  - BUSY, DONE and RESULT go to 0 immediately.
  - No DONE appears after reset is released.
  - The next START completes normally.

Source files
------------

// File: rtl/muldiv_seq_unit.sv
// ============================================================================
// Module   : muldiv_seq_unit
// Brief    : Sequential RV32M multiply/divide unit, one bit per cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_seq_unit #(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            START,
    input  logic [XLEN-1:0] DATA1,
    input  logic [XLEN-1:0] DATA2,
    input  logic [2:0]      SELECT,
    output logic            BUSY,
    output logic            DONE,
    output logic [XLEN-1:0] RESULT
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST_CNT = CW'(XLEN - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     a_q, a_d;
    logic [XLEN-1:0]     d1_q, d1_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic [2:0]          op_q, op_d;
    logic                s1_q, s1_d;
    logic                s2_q, s2_d;
    logic                div0_q, div0_d;
    logic                done_q, done_d;

    logic                w_s1, w_s2;
    logic [XLEN-1:0]     w_mag1, w_mag2;
    logic [XLEN:0]       w_msum;
    logic [2*XLEN-1:0]   w_mstep;
    logic [XLEN:0]       w_shift;
    logic                w_qbit;
    logic [XLEN-1:0]     w_sub, w_rnew;
    logic [2*XLEN-1:0]   w_dstep;
    logic [2*XLEN-1:0]   w_prod;
    logic [XLEN-1:0]     w_quo, w_rem, w_fixed;

    // Operand signedness: rs1 signed for MULH/MULHSU/DIV/REM, rs2 for MULH/DIV/REM.
    always_comb begin
        w_s1   = DATA1[XLEN-1] & ((SELECT == 3'b001) | (SELECT == 3'b010) |
                                  (SELECT == 3'b100) | (SELECT == 3'b110));
        w_s2   = DATA2[XLEN-1] & ((SELECT == 3'b001) | (SELECT == 3'b100) |
                                  (SELECT == 3'b110));
        w_mag1 = w_s1 ? -DATA1 : DATA1;
        w_mag2 = w_s2 ? -DATA2 : DATA2;
    end

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        w_msum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
        w_mstep = {w_msum, acc_q[XLEN-1:1]};

        w_shift = acc_q[2*XLEN-1:XLEN-1];
        w_qbit  = (w_shift >= {1'b0, a_q});
        w_sub   = w_shift[XLEN-1:0] - a_q;
        w_rnew  = w_qbit ? w_sub : w_shift[XLEN-1:0];
        w_dstep = {w_rnew, acc_q[XLEN-2:0], w_qbit};
    end

    always_comb begin
        w_prod = (s1_q ^ s2_q) ? -acc_q : acc_q;
        w_quo  = (s1_q ^ s2_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        w_rem  = s1_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        case (op_q)
            3'b000:                 w_fixed = w_prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_fixed = w_prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         w_fixed = div0_q ? '1 : w_quo;
            default:                w_fixed = div0_q ? d1_q : w_rem;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        a_d      = a_q;
        d1_d     = d1_q;
        result_d = result_q;
        op_d     = op_q;
        s1_d     = s1_q;
        s2_d     = s2_q;
        div0_d   = div0_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    op_d    = SELECT;
                    s1_d    = w_s1;
                    s2_d    = w_s2;
                    d1_d    = DATA1;
                    div0_d  = (DATA2 == '0);
                    cnt_d   = '0;
                    state_d = S_CALC;
                    if (SELECT[2]) begin
                        a_d   = w_mag2;
                        acc_d = {{XLEN{1'b0}}, w_mag1};
                    end else begin
                        a_d   = w_mag1;
                        acc_d = {{XLEN{1'b0}}, w_mag2};
                    end
                end
            end
            S_CALC: begin
                acc_d = op_q[2] ? w_dstep : w_mstep;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                result_d = w_fixed;
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            a_q      <= '0;
            d1_q     <= '0;
            result_q <= '0;
            op_q     <= '0;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            div0_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            a_q      <= a_d;
            d1_q     <= d1_d;
            result_q <= result_d;
            op_q     <= op_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            div0_q   <= div0_d;
            done_q   <= done_d;
        end
    end

    assign BUSY   = (state_q != S_IDLE);
    assign DONE   = done_q;
    assign RESULT = result_q;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_seq_unit.sv
// ============================================================================
// Module   : tb_muldiv_seq_unit
// Brief    : Scoreboard bench for muldiv_seq_unit with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_seq_unit;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        START = 1'b0;
    logic [31:0] DATA1 = '0;
    logic [31:0] DATA2 = '0;
    logic [2:0]  SELECT = '0;
    logic        BUSY, DONE;
    logic [31:0] RESULT;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic prev_done = 1'b0;
    logic [31:0] exp_q[$];
    int          acc_cyc[$];

    muldiv_seq_unit #(.XLEN(32)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .DATA1(DATA1), .DATA2(DATA2),
        .SELECT(SELECT), .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Accepting edges as seen by the bench, for latency measurement.
    always @(posedge CLK) begin
        if (RESET && START && !BUSY) acc_cyc.push_back(cyc);
        cyc <= cyc + 1;
    end

    // Monitor: every DONE pulse consumes one expected result.
    always @(negedge CLK) begin
        if (RESET && DONE) begin
            check("done_not_back_to_back", {31'b0, prev_done}, 32'd0);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: result %h with no pending request", RESULT);
            end else begin
                check("result", RESULT, exp_q.pop_front());
                if (acc_cyc.size() > 0)
                    check("latency", 32'(cyc - 1 - acc_cyc.pop_front()), 32'd33);
                else
                    check("latency_accept_seen", 32'd0, 32'd1);
            end
        end
        prev_done = DONE;
    end

    task automatic drive_start(input logic [2:0] sel, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] exp);
        START  = 1'b1;
        SELECT = sel;
        DATA1  = a;
        DATA2  = b;
        exp_q.push_back(exp);
        @(negedge CLK);
        START = 1'b0;
        DATA1 = $urandom;
        DATA2 = $urandom;
        SELECT = 3'($urandom_range(0, 7));
    endtask

    task automatic issue(input logic [2:0] sel, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
        int n = 0;
        @(negedge CLK);
        while (BUSY && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (BUSY) check("idle_timeout", 32'd1, 32'd0);
        drive_start(sel, a, b, exp);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("done_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    initial begin
        int n;
        #1;
        check("reset_busy", {31'b0, BUSY}, 32'd0);
        check("reset_done", {31'b0, DONE}, 32'd0);
        check("reset_result", RESULT, 32'd0);
        repeat (2) @(negedge CLK);
        RESET = 1'b1;

        // First operation: BUSY width and DONE behaviour.
        drive_start(3'b000, 32'd7, 32'd6, 32'h0000002A);
        n = 1;
        while (BUSY && n < 100) begin
            @(negedge CLK);
            if (BUSY) n++;
        end
        check("busy_cycles", 32'(n), 32'd33);
        wait_drain();
        @(negedge CLK);
        check("idle_busy", {31'b0, BUSY}, 32'd0);
        check("idle_done", {31'b0, DONE}, 32'd0);

        issue(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);
        issue(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        issue(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        issue(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);
        issue(3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);
        issue(3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF);
        issue(3'b101, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC);
        issue(3'b111, 32'hFFFFFFF9, 32'd2, 32'h00000001);
        issue(3'b100, 32'd5, 32'd0, 32'hFFFFFFFF);
        issue(3'b110, 32'd5, 32'd0, 32'h00000005);
        issue(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
        issue(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000);
        issue(3'b001, 32'h00001234, 32'hFFFF0000, 32'hFFFFFFFF);
        issue(3'b101, 32'd5, 32'd0, 32'hFFFFFFFF);
        issue(3'b111, 32'd9, 32'd0, 32'h00000009);
        wait_drain();

        // START pulses while busy must be ignored.
        issue(3'b011, 32'h12345678, 32'h00000010, 32'h00000001);
        repeat (4) @(negedge CLK);
        START = 1'b1; SELECT = 3'b000; DATA1 = 32'd100; DATA2 = 32'd100;
        @(negedge CLK);
        START = 1'b0;
        repeat (14) @(negedge CLK);
        START = 1'b1; SELECT = 3'b101; DATA1 = 32'd77; DATA2 = 32'd3;
        @(negedge CLK);
        START = 1'b0;

        // Back-to-back: new START presented in the DONE cycle.
        n = 0;
        while (!DONE && n < 100) begin
            @(negedge CLK);
            n++;
        end
        check("done_seen_for_holdoff", {31'b0, DONE}, 32'd1);
        drive_start(3'b101, 32'd100, 32'd7, 32'd14);
        check("b2b_busy_rises", {31'b0, BUSY}, 32'd1);
        wait_drain();

        // Asynchronous reset in the middle of CALC.
        issue(3'b000, 32'd5, 32'd5, 32'd25);
        repeat (10) @(negedge CLK);
        #2 RESET = 1'b0;
        #1;
        check("abort_busy", {31'b0, BUSY}, 32'd0);
        check("abort_done", {31'b0, DONE}, 32'd0);
        check("abort_result", RESULT, 32'd0);
        exp_q.delete();
        acc_cyc.delete();
        @(negedge CLK);
        RESET = 1'b1;
        repeat (40) @(negedge CLK);
        issue(3'b111, 32'd100, 32'd7, 32'd2);
        wait_drain();
        repeat (3) @(negedge CLK);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
